// File: rtl/cdb_arbiter_if.sv
// Producer-side result handshakes and registered CDB broadcast of cdb_arbiter.
// slave = arbiter view, master = producer/consumer environment view.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_SIZE_BIT = 5,
  parameter int unsigned DATA_W       = 32
);
  logic                    alu_valid;
  logic [ROB_SIZE_BIT-1:0] alu_rob_id;
  logic [DATA_W-1:0]       alu_value;
  logic                    alu_ready;

  logic                    lsb_valid;
  logic [ROB_SIZE_BIT-1:0] lsb_rob_id;
  logic [DATA_W-1:0]       lsb_value;
  logic                    lsb_ready;

  logic                    cdb_valid;
  logic [ROB_SIZE_BIT-1:0] cdb_rob_id;
  logic [DATA_W-1:0]       cdb_value;
  logic                    cdb_src;

  modport slave (
    input  alu_valid, alu_rob_id, alu_value,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

  modport master (
    output alu_valid, alu_rob_id, alu_value,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs (ALU=0, LSB=1) drained one per cycle onto a registered CDB.
// CDB_LSB_PRIO_EN selects fixed LSB priority; default build is round-robin.
module cdb_arbiter #(
  parameter int unsigned ROB_SIZE_BIT = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned QDEPTH_BIT   = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           rob_clear,
  cdb_arbiter_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << QDEPTH_BIT;
  localparam int unsigned CNT_W = QDEPTH_BIT + 1;
  localparam int unsigned NSRC  = 2;

  typedef struct packed {
    logic [ROB_SIZE_BIT-1:0] rob_id;
    logic [DATA_W-1:0]       value;
  } entry_t;

  entry_t                r_mem  [NSRC][DEPTH];
  logic [QDEPTH_BIT-1:0] r_head [NSRC];
  logic [QDEPTH_BIT-1:0] r_tail [NSRC];
  logic [CNT_W-1:0]      r_cnt  [NSRC];

  logic                    r_cdb_valid;
  logic [ROB_SIZE_BIT-1:0] r_cdb_rob_id;
  logic [DATA_W-1:0]       r_cdb_value;
  logic                    r_cdb_src;

  logic [NSRC-1:0] w_valid;
  logic [NSRC-1:0] w_ready;
  logic [NSRC-1:0] w_nempty;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  entry_t          w_din [NSRC];
  logic            w_active;
  logic            w_gnt_vld;
  logic            w_gnt_src;
  entry_t          w_gnt_entry;

  assign w_active = rdy_in & ~rob_clear;
  assign w_valid  = {bus.lsb_valid, bus.alu_valid};
  assign w_din[0] = {bus.alu_rob_id, bus.alu_value};
  assign w_din[1] = {bus.lsb_rob_id, bus.lsb_value};

  // Per-source circular FIFO: pointers/count and storage
  for (genvar g = 0; g < NSRC; g++) begin : g_fifo
    assign w_ready[g]  = (r_cnt[g] != CNT_W'(DEPTH));
    assign w_nempty[g] = (r_cnt[g] != '0);
    assign w_push[g]   = w_valid[g] & w_ready[g] & w_active;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_head[g] <= '0;
        r_tail[g] <= '0;
        r_cnt[g]  <= '0;
      end else if (rdy_in) begin
        if (rob_clear) begin
          r_head[g] <= '0;
          r_tail[g] <= '0;
          r_cnt[g]  <= '0;
        end else begin
          if (w_push[g]) r_tail[g] <= r_tail[g] + QDEPTH_BIT'(1);
          if (w_pop[g])  r_head[g] <= r_head[g] + QDEPTH_BIT'(1);
          case ({w_push[g], w_pop[g]})
            2'b10:   r_cnt[g] <= r_cnt[g] + CNT_W'(1);
            2'b01:   r_cnt[g] <= r_cnt[g] - CNT_W'(1);
            default: r_cnt[g] <= r_cnt[g];
          endcase
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (w_push[g]) r_mem[g][r_tail[g]] <= w_din[g];
    end
  end

  assign w_gnt_vld = |w_nempty;

`ifdef CDB_LSB_PRIO_EN
  assign w_gnt_src = w_nempty[1];
`else
  logic r_last_grant;

  // On a tie the source that did not win last time is granted
  assign w_gnt_src = (&w_nempty) ? ~r_last_grant : w_nempty[1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_grant <= 1'b1;
    end else if (rdy_in) begin
      if (rob_clear)      r_last_grant <= 1'b1;
      else if (w_gnt_vld) r_last_grant <= w_gnt_src;
    end
  end
`endif

  assign w_pop[0]    = w_active & w_gnt_vld & ~w_gnt_src;
  assign w_pop[1]    = w_active & w_gnt_vld &  w_gnt_src;
  assign w_gnt_entry = r_mem[w_gnt_src][r_head[w_gnt_src]];

  // Registered broadcast; payload fields hold when nothing is granted
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_cdb_valid <= 1'b0;
      end else if (w_gnt_vld) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= w_gnt_entry.rob_id;
        r_cdb_value  <= w_gnt_entry.value;
        r_cdb_src    <= w_gnt_src;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = w_ready[0];
  assign bus.lsb_ready  = w_ready[1];
  assign bus.cdb_valid  = r_cdb_valid;
  assign bus.cdb_rob_id = r_cdb_rob_id;
  assign bus.cdb_value  = r_cdb_value;
  assign bus.cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts queued at stimulus time, checked as the CDB fires.
// Expected orders follow CDB_LSB_PRIO_EN when it is defined.
module tb_cdb_arbiter;

  typedef struct packed {
    logic        src;
    logic [4:0]  id;
    logic [31:0] val;
  } exp_t;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic rob_clear;
  logic rdy_edge;
  logic rst_edge;
  int   n_chk;
  int   n_err;
  exp_t sb_q[$];
  logic [4:0] stall_id;
  logic [4:0] resume_id;

  cdb_arbiter_if #(.ROB_SIZE_BIT(5), .DATA_W(32)) bus ();

  cdb_arbiter #(.ROB_SIZE_BIT(5), .DATA_W(32), .QDEPTH_BIT(2)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] id, input logic [31:0] val);
    bus.alu_valid  = v;
    bus.alu_rob_id = id;
    bus.alu_value  = val;
  endtask

  task automatic set_lsb(input logic v, input logic [4:0] id, input logic [31:0] val);
    bus.lsb_valid  = v;
    bus.lsb_rob_id = id;
    bus.lsb_value  = val;
  endtask

  task automatic exp_push(input logic src, input logic [4:0] id, input logic [31:0] val);
    exp_t e;
    e.src = src;
    e.id  = id;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
  endtask

  // Track whether the edge that produced the current outputs was an active one
  always @(posedge clk_in) begin
    rdy_edge <= rdy_in;
    rst_edge <= rst_in;
  end

  // Consume one expected result per new broadcast
  always @(negedge clk_in) begin
    if (rdy_edge && !rst_edge && bus.cdb_valid) begin
      if (sb_q.size() == 0) begin
        chk("cdb_unexpected", 64'(bus.cdb_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("cdb_src",   64'(bus.cdb_src),    64'(e.src));
        chk("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(e.id));
        chk("cdb_value", 64'(bus.cdb_value),  64'(e.val));
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rdy_edge  = 1'b0;
    rst_edge  = 1'b1;
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    rob_clear = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    step();
    step();
    rst_in = 1'b0;

    // Reset state
    chk("rst_valid",  64'(bus.cdb_valid),  64'(0));
    chk("rst_rob_id", 64'(bus.cdb_rob_id), 64'(0));
    chk("rst_value",  64'(bus.cdb_value),  64'(0));
    chk("rst_src",    64'(bus.cdb_src),    64'(0));
    chk("rst_alu_rdy", 64'(bus.alu_ready), 64'(1));
    chk("rst_lsb_rdy", 64'(bus.lsb_ready), 64'(1));

    // Single ALU result: one-cycle latency, then valid drops with payload held
    exp_push(1'b0, 5'd3, 32'h11);
    set_alu(1'b1, 5'd3, 32'h11);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("lat_push_cycle", 64'(bus.cdb_valid), 64'(0));
    step();
    chk("lat_valid",  64'(bus.cdb_valid),  64'(1));
    chk("lat_rob_id", 64'(bus.cdb_rob_id), 64'(3));
    step();
    chk("lat_drop",   64'(bus.cdb_valid),  64'(0));
    chk("lat_hold_id", 64'(bus.cdb_rob_id), 64'(3));

    // Simultaneous pushes from both producers over two cycles
    flush();
`ifdef CDB_LSB_PRIO_EN
    exp_push(1'b1, 5'd8, 32'h808);
    exp_push(1'b1, 5'd9, 32'h909);
    exp_push(1'b0, 5'd1, 32'h101);
    exp_push(1'b0, 5'd2, 32'h202);
`else
    exp_push(1'b0, 5'd1, 32'h101);
    exp_push(1'b1, 5'd8, 32'h808);
    exp_push(1'b0, 5'd2, 32'h202);
    exp_push(1'b1, 5'd9, 32'h909);
`endif
    set_alu(1'b1, 5'd1, 32'h101);
    set_lsb(1'b1, 5'd8, 32'h808);
    step();
    set_alu(1'b1, 5'd2, 32'h202);
    set_lsb(1'b1, 5'd9, 32'h909);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tie_no_bubble", 64'(bus.cdb_valid), 64'(1));
      step();
    end
    chk("tie_drained", 64'(bus.cdb_valid), 64'(0));

    // Both producers push every cycle for 7 cycles; FIFOs fill up
    flush();
`ifdef CDB_LSB_PRIO_EN
    for (int i = 0; i < 7; i++) exp_push(1'b1, 5'(20 + i), 32'hB000 + 32'(i));
    for (int i = 0; i < 4; i++) exp_push(1'b0, 5'(10 + i), 32'hA000 + 32'(i));
`else
    for (int i = 0; i < 6; i++) begin
      exp_push(1'b0, 5'(10 + i), 32'hA000 + 32'(i));
      exp_push(1'b1, 5'(20 + i), 32'hB000 + 32'(i));
    end
    exp_push(1'b0, 5'd16, 32'hA006);
`endif
    for (int i = 0; i < 7; i++) begin
      set_alu(1'b1, 5'(10 + i), 32'hA000 + 32'(i));
      set_lsb(1'b1, 5'(20 + i), 32'hB000 + 32'(i));
      step();
`ifdef CDB_LSB_PRIO_EN
      if (i == 3) chk("full_alu_rdy", 64'(bus.alu_ready), 64'(0));
`else
      if (i == 5) chk("full_lsb_rdy", 64'(bus.lsb_ready), 64'(0));
`endif
    end
    chk("full_alu_rdy_end", 64'(bus.alu_ready), 64'(0));
    chk("full_lsb_rdy_end", 64'(bus.lsb_ready), 64'(1));
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("full_drained", 64'(bus.cdb_valid), 64'(0));

    // Flush with queued entries and a concurrent ALU offer (id 7 must vanish)
    flush();
`ifdef CDB_LSB_PRIO_EN
    exp_push(1'b1, 5'd24, 32'hC100);
    exp_push(1'b1, 5'd25, 32'hC101);
`else
    exp_push(1'b0, 5'd11, 32'hC000);
    exp_push(1'b1, 5'd24, 32'hC100);
`endif
    set_alu(1'b1, 5'd11, 32'hC000);
    set_lsb(1'b1, 5'd24, 32'hC100);
    step();
    set_alu(1'b1, 5'd12, 32'hC001);
    set_lsb(1'b1, 5'd25, 32'hC101);
    step();
    set_alu(1'b1, 5'd13, 32'hC002);
    set_lsb(1'b0, 5'd0, 32'd0);
    step();
    set_alu(1'b1, 5'd7, 32'h777);
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    chk("clr_valid",   64'(bus.cdb_valid), 64'(0));
    chk("clr_alu_rdy", 64'(bus.alu_ready), 64'(1));
    chk("clr_lsb_rdy", 64'(bus.lsb_ready), 64'(1));
    for (int i = 0; i < 4; i++) step();
    chk("clr_quiet", 64'(bus.cdb_valid), 64'(0));

    // Global stall with entries queued and producers still offering
`ifdef CDB_LSB_PRIO_EN
    stall_id  = 5'd8;
    resume_id = 5'd9;
    exp_push(1'b1, 5'd8, 32'h808);
    exp_push(1'b1, 5'd9, 32'h909);
    exp_push(1'b0, 5'd1, 32'h101);
    exp_push(1'b0, 5'd2, 32'h202);
`else
    stall_id  = 5'd1;
    resume_id = 5'd8;
    exp_push(1'b0, 5'd1, 32'h101);
    exp_push(1'b1, 5'd8, 32'h808);
    exp_push(1'b0, 5'd2, 32'h202);
    exp_push(1'b1, 5'd9, 32'h909);
`endif
    set_alu(1'b1, 5'd1, 32'h101);
    set_lsb(1'b1, 5'd8, 32'h808);
    step();
    set_alu(1'b1, 5'd2, 32'h202);
    set_lsb(1'b1, 5'd9, 32'h909);
    step();
    set_alu(1'b1, 5'd3, 32'h303);
    set_lsb(1'b1, 5'd10, 32'hA0A);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid",  64'(bus.cdb_valid),  64'(1));
      chk("stall_rob_id", 64'(bus.cdb_rob_id), 64'(stall_id));
      chk("stall_alu_rdy", 64'(bus.alu_ready), 64'(1));
    end
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    rdy_in = 1'b1;
    step();
    chk("resume_rob_id", 64'(bus.cdb_rob_id), 64'(resume_id));
    for (int i = 0; i < 4; i++) step();
    chk("resume_drained", 64'(bus.cdb_valid), 64'(0));

    // Reset mid-operation beats rob_clear and a low rdy_in
    flush();
`ifdef CDB_LSB_PRIO_EN
    exp_push(1'b1, 5'd22, 32'hE000);
    exp_push(1'b1, 5'd23, 32'hE001);
    exp_push(1'b1, 5'd24, 32'hE002);
`else
    exp_push(1'b0, 5'd12, 32'hD000);
    exp_push(1'b1, 5'd22, 32'hE000);
    exp_push(1'b0, 5'd13, 32'hD001);
`endif
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'(12 + i), 32'hD000 + 32'(i));
      set_lsb(1'b1, 5'(22 + i), 32'hE000 + 32'(i));
      step();
    end
    rst_in    = 1'b1;
    rob_clear = 1'b1;
    rdy_in    = 1'b0;
    step();
    rst_in    = 1'b0;
    rob_clear = 1'b0;
    rdy_in    = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    chk("mrst_valid",  64'(bus.cdb_valid),  64'(0));
    chk("mrst_rob_id", 64'(bus.cdb_rob_id), 64'(0));
    chk("mrst_value",  64'(bus.cdb_value),  64'(0));
    chk("mrst_src",    64'(bus.cdb_src),    64'(0));
    chk("mrst_alu_rdy", 64'(bus.alu_ready), 64'(1));
    chk("mrst_lsb_rdy", 64'(bus.lsb_ready), 64'(1));
`ifdef CDB_LSB_PRIO_EN
    exp_push(1'b1, 5'd6, 32'h66);
    exp_push(1'b0, 5'd5, 32'h55);
`else
    exp_push(1'b0, 5'd5, 32'h55);
    exp_push(1'b1, 5'd6, 32'h66);
`endif
    set_alu(1'b1, 5'd5, 32'h55);
    set_lsb(1'b1, 5'd6, 32'h66);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    step();
`ifdef CDB_LSB_PRIO_EN
    chk("mrst_first_src", 64'(bus.cdb_src), 64'(1));
`else
    chk("mrst_first_src", 64'(bus.cdb_src), 64'(0));
`endif
    for (int i = 0; i < 4; i++) step();

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single ROB finish port (common data bus) between the two producers, the ALU/RS path and the LSB.
Each producer pushes {rob_id, value} into its own small FIFO. The arbiter pops one entry per cycle and broadcasts it on a registered CDB, which drives the ROB's rs_fi/rs_value/rs_rob_id inputs and the RS/LSB wake-up.
A misprediction clear (rob_clear) flushes all queued results.

Parameters:
ROB_SIZE_BIT, 5, width of ROB index.
DATA_W, 32, result value width.
QDEPTH_BIT, 2, log2 of per-source FIFO depth (depth 4).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
rdy_in  input  1  global stall; low freezes all state
rob_clear  input  1  ROB flush request
alu_valid  input  1  ALU result offered
alu_rob_id  input  ROB_SIZE_BIT  ROB entry of ALU result
alu_value  input  DATA_W  ALU result
alu_ready  output  1  ALU FIFO can accept
lsb_valid  input  1  LSB result offered
lsb_rob_id  input  ROB_SIZE_BIT  ROB entry of load/store
lsb_value  input  DATA_W  load data (0 for stores)
lsb_ready  output  1  LSB FIFO can accept
cdb_valid  output  1  broadcast valid (registered)
cdb_rob_id  output  ROB_SIZE_BIT  broadcast ROB id (registered)
cdb_value  output  DATA_W  broadcast value (registered)
cdb_src  output  1  0 = ALU, 1 = LSB (registered)

Behaviour:
- Clocking and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- State at reset:
  - Both FIFOs empty; head/tail/count = 0.
  - cdb_valid = 0, cdb_rob_id = 0, cdb_value = 0, cdb_src = 0.
  - Round-robin pointer last_grant = 1 (LSB), so the ALU wins the first tie.
- Stall: when rdy_in = 0, no push, pop, pointer or output register changes.
- Ready outputs:
  - alu_ready = (alu_count != 2^QDEPTH_BIT). lsb_ready is defined the same way on the LSB FIFO.
  - Ready is combinational from count only and does not depend on valid.
- Push: occurs when valid && ready && rdy_in && !rob_clear. Data is written at the tail; tail wraps modulo depth.
- Pop/grant: evaluated each active cycle on FIFO contents at the start of the cycle, so a same-cycle push is not visible.
  - Only one source non-empty: that source is granted.
  - Both non-empty: grant the source != last_grant, then last_grant <= granted source.
  - Granted head is loaded into the cdb_* registers with cdb_valid <= 1. Head advances, wrapping.
  - Neither non-empty: cdb_valid <= 0. The other cdb_* fields hold their previous values.
- Latency: an entry pushed into an empty FIFO in cycle N appears on the CDB in cycle N+1 at the earliest.
- Sustained throughput: 1 result per cycle total. With both sources busy, each source gets 1 result per 2 cycles.
- Simultaneous push and pop on the same FIFO: count is unchanged. This is legal when full, but ready stays 0 when full, so no push happens that cycle.
- Flush: rob_clear = 1 (with rdy_in = 1) for one cycle:
  - Both FIFOs are emptied and cdb_valid <= 0.
  - Pushes offered that cycle are dropped.
  - last_grant is reset to 1.
  - No grant occurs that cycle.
- Reset asserted mid-operation: same as the reset state above; takes precedence over rob_clear and rdy_in.
- The CDB carries no backpressure: the ROB/RS/LSB always consume a valid broadcast.

Optional Feature:
CDB_LSB_PRIO_EN
- Defined: fixed priority. The LSB is granted whenever its FIFO is non-empty, which frees load-dependent consumers sooner. last_grant is not used.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset, then ALU push {id=3, value=0x11} at cycle 1 -> cycle 2: cdb_valid=1, cdb_rob_id=3, cdb_value=0x11, cdb_src=0. Cycle 3: cdb_valid=0.
- ALU pushes ids 1,2 and LSB pushes ids 8,9 simultaneously in two consecutive cycles -> CDB order ALU1, LSB8, ALU2, LSB9, one per cycle with no bubble after the first. With CDB_LSB_PRIO_EN, the order is LSB8, LSB9, ALU1, ALU2.
- Fill ALU FIFO with 4 entries while LSB continuously wins (CDB_LSB_PRIO_EN, LSB kept non-empty) -> alu_ready=0 after the 4th push. A 5th alu_valid is not accepted and the FIFO contents are unchanged.
- Queue 3 ALU and 2 LSB entries, pulse rob_clear together with a new alu_valid {id=7} -> next cycle cdb_valid=0, both readies=1, id 7 never broadcast.
- Hold rdy_in=0 for 3 cycles with entries queued and valids asserted -> cdb_* registers and counts are frozen. On rdy_in=1, broadcasting resumes in the original order and no entry is duplicated or lost.
- Assert rst_in for one cycle while both FIFOs are full -> next cycle all outputs are at reset values, both readies=1, and the first tie after reset grants the ALU.
